// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bundles the MEM/WB write-back inputs, the two ID-stage read
// ports and the debug/observation outputs of the write-back register file.
//   master : drives in_WB/in_red/in_res/in_mux and rs_addr/rt_addr,
//            observes rs_data/rt_data/wb_data/wb_we/commit_count
//   slave  : the register file itself (opposite directions)
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
);
    logic [1:0]        in_WB;         // [1]=RegWrite, [0]=MemtoReg
    logic [DATA_W-1:0] in_red;        // memory read data
    logic [DATA_W-1:0] in_res;        // ALU result
    logic [ADDR_W-1:0] in_mux;        // destination register index
    logic [ADDR_W-1:0] rs_addr;       // read port A index
    logic [ADDR_W-1:0] rt_addr;       // read port B index
    logic [DATA_W-1:0] rs_data;       // read port A data (combinational)
    logic [DATA_W-1:0] rt_data;       // read port B data (combinational)
    logic [DATA_W-1:0] wb_data;       // selected write-back value (combinational)
    logic              wb_we;         // effective write enable (combinational)
    logic [CNT_W-1:0]  commit_count;  // committed register writes (registered)

    modport master (
        output in_WB, in_red, in_res, in_mux, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wb_we, commit_count
    );

    modport slave (
        input  in_WB, in_red, in_res, in_mux, rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wb_we, commit_count
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage plus architectural register file.
//   Selects the write-back value (load data or ALU result), commits it to a
//   2**ADDR_W x DATA_W register file, serves two ID-stage read ports with
//   same-cycle write-to-read bypass, and counts retired register writes.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high (clears array and counter)
//   bus  : wb_regfile_if.slave (write-back inputs, read ports, wb_data,
//          wb_we, commit_count)
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    // Write-back value selection and effective enable; index 0 is $zero.
    always_comb begin
        wb_data = bus.in_WB[0] ? bus.in_red : bus.in_res;
        wb_we   = bus.in_WB[1] & (bus.in_mux != '0) & ~rst;
    end

    // Read with write-first bypass so a dependent ID-stage read sees the
    // value retiring in this same cycle.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = regs[addr];
        if (addr == '0) begin
            value = '0;
        end else if (wb_we && (addr == bus.in_mux)) begin
            value = wb_data;
        end
        return value;
    endfunction

    always_comb begin
        rs_data = read_port(bus.rs_addr);
        rt_data = read_port(bus.rt_addr);
    end

    // Array and commit counter; reset wins over any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
            count_q <= '0;
        end else if (wb_we) begin
            regs[bus.in_mux] <= wb_data;
            count_q          <= count_q + CNT_W'(1);
        end
    end

    assign bus.wb_data      = wb_data;
    assign bus.wb_we        = wb_we;
    assign bus.rs_data      = rs_data;
    assign bus.rt_data      = rt_data;
    assign bus.commit_count = count_q;

    // Control from MEM/WB must be fully driven once out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!$isunknown(bus.in_WB))
                else $error("wb_regfile: in_WB unknown outside reset");
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed bench for wb_regfile. Two instances (CNT_W=32 and
// CNT_W=4) receive identical stimulus; each step queues the hand-computed
// outputs and a monitor compares them half a cycle later.
module tb_wb_regfile;

    logic clk;
    logic rst;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus  ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] wbd;
        logic        we;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s got %h expected %h", tag, fld, act, req);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, compare every pending expectation.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "rs_data",   bus.rs_data,  e.rs);
            chk(e.tag, "rt_data",   bus.rt_data,  e.rt);
            chk(e.tag, "wb_data",   bus.wb_data,  e.wbd);
            chk(e.tag, "wb_we",     32'(bus.wb_we), 32'(e.we));
            chk(e.tag, "count",     bus.commit_count, e.cnt);
            chk(e.tag, "rs_data4",  bus4.rs_data, e.rs);
            chk(e.tag, "rt_data4",  bus4.rt_data, e.rt);
            chk(e.tag, "wb_we4",    32'(bus4.wb_we), 32'(e.we));
            chk(e.tag, "count4",    32'(bus4.commit_count), 32'(e.cnt4));
        end
    end

    task automatic drive(input logic r, input logic [1:0] wb,
                         input logic [31:0] red, input logic [31:0] res,
                         input logic [4:0] mux, input logic [4:0] rsa,
                         input logic [4:0] rta);
        rst          = r;
        bus.in_WB    = wb;   bus4.in_WB   = wb;
        bus.in_red   = red;  bus4.in_red  = red;
        bus.in_res   = res;  bus4.in_res  = res;
        bus.in_mux   = mux;  bus4.in_mux  = mux;
        bus.rs_addr  = rsa;  bus4.rs_addr = rsa;
        bus.rt_addr  = rta;  bus4.rt_addr = rta;
    endtask

    // One cycle: apply inputs just after the edge and queue the outputs
    // expected before the next edge.
    task automatic step(input string tag, input logic r, input logic [1:0] wb,
                        input logic [31:0] red, input logic [31:0] res,
                        input logic [4:0] mux, input logic [4:0] rsa,
                        input logic [4:0] rta,
                        input logic [31:0] e_rs, input logic [31:0] e_rt,
                        input logic [31:0] e_wbd, input logic e_we,
                        input logic [31:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        drive(r, wb, red, res, mux, rsa, rta);
        e.tag  = tag;
        e.rs   = e_rs;
        e.rt   = e_rt;
        e.wbd  = e_wbd;
        e.we   = e_we;
        e.cnt  = e_cnt;
        e.cnt4 = 4'(e_cnt);
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 2'b10, 32'h0, 32'h7, 5'd7, 5'd0, 5'd0);

        // Reset held: every index reads 0, pending writes are suppressed.
        for (int i = 0; i < 32; i++) begin
            step("rst", 1'b1, 2'b10, 32'h0, 32'(i), 5'(i), 5'(i), 5'(31 - i),
                 32'h0, 32'h0, 32'(i), 1'b0, 32'd0);
        end

        step("alu_wr",  1'b0, 2'b10, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0,
             32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'd0);
        step("alu_rd",  1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5,
             32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'd1);
        step("ld_byp",  1'b0, 2'b11, 32'h1234_5678, 32'hAAAA_0000, 5'd9, 5'd5, 5'd9,
             32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'd1);
        step("no_wr",   1'b0, 2'b00, 32'h0, 32'h1, 5'd5, 5'd9, 5'd9,
             32'h1234_5678, 32'h1234_5678, 32'h1, 1'b0, 32'd2);
        step("zero_wr", 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd5,
             32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'd2);
        step("zero_rd", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9,
             32'h0, 32'h1234_5678, 32'h0, 1'b0, 32'd2);
        step("sel_red", 1'b0, 2'b01, 32'hCAFE_F00D, 32'h0, 5'd3, 5'd3, 5'd3,
             32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'd2);
        step("ovr_byp", 1'b0, 2'b10, 32'h0, 32'h0000_0011, 5'd5, 5'd5, 5'd5,
             32'h0000_0011, 32'h0000_0011, 32'h0000_0011, 1'b1, 32'd2);
        step("ovr_rd",  1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd9,
             32'h0000_0011, 32'h1234_5678, 32'h0, 1'b0, 32'd3);

        // Reset during a write: no bypass, value never lands, counter clears.
        step("rst_mid", 1'b1, 2'b10, 32'h0, 32'h7, 5'd7, 5'd7, 5'd5,
             32'h0, 32'h0000_0011, 32'h7, 1'b0, 32'd3);
        step("rst_aft", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd5,
             32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        // Sixteen writes: 4-bit counter reaches 15 then wraps to 0.
        for (int k = 1; k <= 16; k++) begin
            step("wrap", 1'b0, 2'b10, 32'h0, 32'(k), 5'(k), 5'(k), 5'(k - 1),
                 32'(k), 32'(k - 1), 32'(k), 1'b1, 32'(k - 1));
        end
        step("wrap_end", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd16, 5'd1,
             32'd16, 32'd1, 32'h0, 1'b0, 32'd16);

        @(posedge clk);
        #1;
        chk("drain", "queue_left", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
